// File: rtl/srm_pkg.sv
// Shared definitions for the Simple RISC Machine branch path: branch
// operation codes, condition codes, branch FSM states and status flag positions.
package srm_pkg;

    // Branch operation codes carried on br_op
    typedef enum logic [1:0] {
        OP_B   = 2'b00,
        OP_BL  = 2'b01,
        OP_BX  = 2'b10,
        OP_BLX = 2'b11
    } br_op_e;

    // Condition codes for conditional B (only meaningful with OP_B)
    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_BEQ = 3'b001;
    localparam logic [2:0] COND_BNE = 3'b010;
    localparam logic [2:0] COND_BLT = 3'b011;
    localparam logic [2:0] COND_BLE = 3'b100;

    // Branch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EVAL   = 2'b01,
        ST_LINK   = 2'b10,
        ST_UPDATE = 2'b11
    } br_state_e;

    // Bit positions inside the {Z,V,N} status vector
    localparam int STATUS_Z = 2;
    localparam int STATUS_V = 1;
    localparam int STATUS_N = 0;

    // True for the operations that also write the return address to R7
    function automatic logic op_links(br_op_e op);
        return (op == OP_BL) || (op == OP_BLX);
    endfunction

endpackage

// File: rtl/branch_unit_if.sv
// Controller-side bundle for the branch unit: status capture, branch request
// operands and the PC / link write-back outputs.
interface branch_unit_if #(
    parameter int PCW = 9,
    parameter int DW  = 16
);
    logic           load_s;
    logic [2:0]     status_in;
    logic [2:0]     status_q;
    logic           br_req;
    logic [1:0]     br_op;
    logic [2:0]     cond;
    logic [7:0]     imm8;
    logic [PCW-1:0] pc_in;
    logic [DW-1:0]  reg_in;
    logic           br_ready;
    logic           taken;
    logic           write_link;
    logic [DW-1:0]  link_out;
    logic           load_pc;
    logic [PCW-1:0] pc_out;
    logic           br_done;

    // Controller / datapath side
    modport master (
        output load_s, status_in, br_req, br_op, cond, imm8, pc_in, reg_in,
        input  status_q, br_ready, taken, write_link, link_out, load_pc, pc_out, br_done
    );

    // Branch unit side
    modport slave (
        input  load_s, status_in, br_req, br_op, cond, imm8, pc_in, reg_in,
        output status_q, br_ready, taken, write_link, link_out, load_pc, pc_out, br_done
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: maps a condition code and {Z,V,N}
// flags to a take decision. Unused codes never take.
module branch_cond_eval
    import srm_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       take_o
);
    logic z, v, n;

    assign z = flags_i[STATUS_Z];
    assign v = flags_i[STATUS_V];
    assign n = flags_i[STATUS_N];

    // Decode the condition against the flags
    always_comb begin
        take_o = 1'b0;
        case (cond_i)
            COND_B:   take_o = 1'b1;
            COND_BEQ: take_o = z;
            COND_BNE: take_o = ~z;
            COND_BLT: take_o = n ^ v;
            COND_BLE: take_o = (n ^ v) | z;
            default:  take_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_unit.sv
// Branch unit: status register, branch sequencer (IDLE/EVAL/LINK/UPDATE),
// operand latches and target adder. Produces one-cycle load_pc / write_link
// pulses for the PC register and register-file R7 port. Assumes PCW > 8.
module branch_unit
    import srm_pkg::*;
#(
    parameter int PCW = 9,
    parameter int DW  = 16
)(
    input  logic         clk,
    input  logic         reset,
    branch_unit_if.slave bus
);
    logic [2:0]     status_q;
    br_state_e      state_q;

    // Operands latched at accept
    br_op_e         op_q;
    logic [2:0]     cond_q;
    logic [7:0]     imm8_q;
    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] reg_tgt_q;
    logic [2:0]     flags_q;

    // Registered outputs
    logic           ready_q;
    logic           taken_q;
    logic           write_link_q;
    logic           load_pc_q;
    logic           br_done_q;
    logic [DW-1:0]  link_q;
    logic [PCW-1:0] pc_out_q;

    // Next-value datapath derived from the latched operands
    logic           cond_take_d;
    logic           take_d;
    logic [PCW-1:0] pc_plus1_d;
    logic [PCW-1:0] target_d;
    logic [PCW-1:0] pc_next_d;

    // Only the low PCW bits of Rd form a BX/BLX target
    logic           unused_reg_hi;
    assign unused_reg_hi = ^bus.reg_in[DW-1:PCW];

    branch_cond_eval u_cond (
        .cond_i  (cond_q),
        .flags_i (flags_q),
        .take_o  (cond_take_d)
    );

    // Target adder: relative for B/BL, register-indirect for BX/BLX, all modulo 2^PCW
    always_comb begin
        pc_plus1_d = pc_q + PCW'(1);
        take_d     = (op_q == OP_B) ? cond_take_d : 1'b1;
        if ((op_q == OP_B) || (op_q == OP_BL))
            target_d = pc_plus1_d + {{(PCW-8){imm8_q[7]}}, imm8_q};
        else
            target_d = reg_tgt_q;
        pc_next_d  = take_d ? target_d : pc_plus1_d;
    end

    // Status register: captures ALU flags whenever load_s is set, whatever the sequencer does
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            status_q <= 3'b000;
        else if (bus.load_s)
            status_q <= bus.status_in;
    end

    // Branch sequencer with registered handshake and write-back outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_B;
            cond_q       <= 3'b000;
            imm8_q       <= 8'h00;
            pc_q         <= '0;
            reg_tgt_q    <= '0;
            flags_q      <= 3'b000;
            ready_q      <= 1'b1;
            taken_q      <= 1'b0;
            write_link_q <= 1'b0;
            load_pc_q    <= 1'b0;
            br_done_q    <= 1'b0;
            link_q       <= '0;
            pc_out_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.br_req) begin
                        op_q      <= br_op_e'(bus.br_op);
                        cond_q    <= bus.cond;
                        imm8_q    <= bus.imm8;
                        pc_q      <= bus.pc_in;
                        reg_tgt_q <= bus.reg_in[PCW-1:0];
                        // Register value before any same-cycle load_s update
                        flags_q   <= status_q;
                        ready_q   <= 1'b0;
                        state_q   <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (op_links(op_q)) begin
                        write_link_q <= 1'b1;
                        link_q       <= {{(DW-PCW){1'b0}}, pc_plus1_d};
                        state_q      <= ST_LINK;
                    end else begin
                        load_pc_q <= 1'b1;
                        br_done_q <= 1'b1;
                        taken_q   <= take_d;
                        pc_out_q  <= pc_next_d;
                        state_q   <= ST_UPDATE;
                    end
                end
                ST_LINK: begin
                    write_link_q <= 1'b0;
                    load_pc_q    <= 1'b1;
                    br_done_q    <= 1'b1;
                    taken_q      <= take_d;
                    pc_out_q     <= pc_next_d;
                    state_q      <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    load_pc_q <= 1'b0;
                    br_done_q <= 1'b0;
                    taken_q   <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.status_q   = status_q;
    assign bus.br_ready   = ready_q;
    assign bus.taken      = taken_q;
    assign bus.write_link = write_link_q;
    assign bus.link_out   = link_q;
    assign bus.load_pc    = load_pc_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.br_done    = br_done_q;
endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus randomized
// branches checked against an arithmetic reference model of the branch rules.
module tb_branch_unit;
    localparam int PCW = 9;
    localparam int DW  = 16;
    localparam int PCM = 1 << PCW;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   model_status;

    branch_unit_if #(.PCW(PCW), .DW(DW)) bus ();

    branch_unit #(.PCW(PCW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: branch outcome straight from the architectural rules
    task automatic model(input int op, input int cnd, input int flags, input int pc,
                         input int imm, input int regv,
                         output int tk, output int pcn, output int lnk, output int lval);
        int z, v, n, pc1, off, tgt;
        z   = (flags >> 2) & 1;
        v   = (flags >> 1) & 1;
        n   = flags & 1;
        pc1 = (pc + 1) % PCM;
        off = (imm >= 128) ? imm - 256 : imm;
        if (op == 0) begin
            case (cnd)
                0:       tk = 1;
                1:       tk = z;
                2:       tk = (z == 0) ? 1 : 0;
                3:       tk = (n != v) ? 1 : 0;
                4:       tk = ((n != v) || (z == 1)) ? 1 : 0;
                default: tk = 0;
            endcase
        end else begin
            tk = 1;
        end
        if (op <= 1) tgt = (((pc + 1 + off) % PCM) + PCM) % PCM;
        else         tgt = regv % PCM;
        pcn  = (tk != 0) ? tgt : pc1;
        lnk  = (op == 1 || op == 3) ? 1 : 0;
        lval = pc1;
    endtask

    task automatic load_status(input int st);
        @(negedge clk);
        bus.load_s    = 1'b1;
        bus.status_in = 3'(st);
        @(posedge clk);
        model_status = st;
        @(negedge clk);
        bus.load_s = 1'b0;
        chk("status_load", 32'(bus.status_q), 32'(model_status));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.br_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", 32'(bus.br_ready), 32'd1);
    endtask

    // One full branch transaction, driven and sampled on falling edges
    task automatic run_branch(input int op, input int cnd, input int imm, input int pc,
                              input int regv, input bit ls, input int st, input bit hold_req);
        int tk, pcn, lnk, lval;
        @(negedge clk);
        wait_ready();
        model(op, cnd, model_status, pc, imm, regv, tk, pcn, lnk, lval);
        bus.br_req    = 1'b1;
        bus.br_op     = 2'(op);
        bus.cond      = 3'(cnd);
        bus.imm8      = 8'(imm);
        bus.pc_in     = 9'(pc);
        bus.reg_in    = 16'(regv);
        bus.load_s    = ls;
        bus.status_in = 3'(st);
        @(posedge clk);
        if (ls) model_status = st;
        @(negedge clk);
        if (!hold_req) bus.br_req = 1'b0;
        bus.load_s = 1'b0;
        chk("eval_ready", 32'(bus.br_ready), 32'd0);
        chk("eval_load_pc", 32'(bus.load_pc), 32'd0);
        chk("eval_write_link", 32'(bus.write_link), 32'd0);
        chk("status_q", 32'(bus.status_q), 32'(model_status));
        if (lnk != 0) begin
            @(negedge clk);
            chk("link_write_link", 32'(bus.write_link), 32'd1);
            chk("link_out", 32'(bus.link_out), 32'(lval));
            chk("link_load_pc", 32'(bus.load_pc), 32'd0);
            chk("link_ready", 32'(bus.br_ready), 32'd0);
        end
        @(negedge clk);
        chk("upd_load_pc", 32'(bus.load_pc), 32'd1);
        chk("upd_br_done", 32'(bus.br_done), 32'd1);
        chk("upd_taken", 32'(bus.taken), 32'(tk));
        chk("upd_pc_out", 32'(bus.pc_out), 32'(pcn));
        chk("upd_write_link", 32'(bus.write_link), 32'd0);
        chk("upd_ready", 32'(bus.br_ready), 32'd0);
        bus.br_req = 1'b0;
        @(negedge clk);
        chk("post_ready", 32'(bus.br_ready), 32'd1);
        chk("post_load_pc", 32'(bus.load_pc), 32'd0);
        chk("post_br_done", 32'(bus.br_done), 32'd0);
        $display("txn op=%0d cond=%0d pc=%03h imm=%02h reg=%04h -> taken=%0d pc_out=%03h link=%0d",
                 op, cnd, pc, imm, regv, bus.taken, pcn, lnk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_status = 0;
        reset = 1'b1;
        bus.load_s = 1'b0; bus.status_in = 3'b000; bus.br_req = 1'b0;
        bus.br_op = 2'b00; bus.cond = 3'b000; bus.imm8 = 8'h00;
        bus.pc_in = '0; bus.reg_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.br_ready), 32'd1);
        chk("rst_status", 32'(bus.status_q), 32'd0);
        chk("rst_load_pc", 32'(bus.load_pc), 32'd0);
        chk("rst_write_link", 32'(bus.write_link), 32'd0);
        chk("rst_br_done", 32'(bus.br_done), 32'd0);
        chk("rst_taken", 32'(bus.taken), 32'd0);
        reset = 1'b0;

        // Reset while a BL sits in LINK aborts it
        load_status(3'b101);
        @(negedge clk);
        bus.br_req = 1'b1; bus.br_op = 2'b01; bus.imm8 = 8'h02; bus.pc_in = 9'h1FF;
        @(posedge clk);
        @(negedge clk);
        bus.br_req = 1'b0;
        @(negedge clk);
        chk("abort_in_link", 32'(bus.write_link), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.br_ready), 32'd1);
        chk("abort_status", 32'(bus.status_q), 32'd0);
        chk("abort_write_link", 32'(bus.write_link), 32'd0);
        model_status = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_load_pc", 32'(bus.load_pc), 32'd0);
            chk("abort_no_link", 32'(bus.write_link), 32'd0);
        end

        // BEQ with Z set and clear
        load_status(3'b100);
        run_branch(0, 1, 8'h05, 9'h010, 0, 1'b0, 0, 1'b0);
        load_status(3'b000);
        run_branch(0, 1, 8'h05, 9'h010, 0, 1'b0, 0, 1'b0);

        // BLT / BLE / reserved cond across all flag values
        for (int f = 0; f < 8; f++) begin
            load_status(f);
            run_branch(0, 3, 8'h10, 9'h040, 0, 1'b0, 0, 1'b0);
            run_branch(0, 4, 8'hFF, 9'h000, 0, 1'b0, 0, 1'b0);
            run_branch(0, 6, 8'h03, 9'h100, 0, 1'b0, 0, 1'b0);
        end

        // BL wrap-around, BLX and BX register targets
        run_branch(1, 0, 8'h02, 9'h1FF, 0, 1'b0, 0, 1'b0);
        run_branch(3, 0, 8'h00, 9'h020, 16'hFF45, 1'b0, 0, 1'b0);
        run_branch(2, 0, 8'h00, 9'h020, 16'h0007, 1'b0, 0, 1'b0);

        // Same-cycle load_s and BNE accept uses old flags; br_req held through EVAL
        load_status(3'b000);
        run_branch(0, 2, 8'h04, 9'h030, 0, 1'b1, 3'b100, 1'b1);
        chk("bne_status_after", 32'(bus.status_q), 32'd4);

        // Randomized branches with random status traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) load_status($urandom_range(0, 7));
            run_branch($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255),
                       $urandom_range(0, PCM - 1), $urandom_range(0, 65535),
                       1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
